// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, bit levels and baud arithmetic.
package uart_pkg;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_t;

    // Clock cycles per bit, integer division
    function automatic int unsigned bitcyc(input int unsigned fclk, input int unsigned fbaud);
        return fclk / fbaud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-width down-counter: reloads to BITCYC-1 on load, otherwise counts down and holds at 0.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned FCLK  = 50000000,
    parameter int unsigned FBAUD = 115200
) (
    input  logic clk50m,
    input  logic rst_n,
    input  logic load,
    output logic zero,
    output logic half
);

    localparam int unsigned BITCYC = bitcyc(FCLK, FBAUD);
    localparam int unsigned CW     = $clog2(BITCYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(BITCYC - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
    assign half = (cnt == CW'(BITCYC / 2));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB first, stop bit; no parity.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FCLK  = 50000000,
    parameter int unsigned FBAUD = 115200
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_start,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_idle,
    output logic             tx_done
);

    localparam int unsigned BCW = $clog2(WIDTH);

    uart_tx_state_t   state;
    logic [WIDTH-1:0] shreg;
    logic [BCW-1:0]   bit_cnt;
    logic             baud_load_c;
    logic             baud_zero;
    logic             baud_half_unused;

    // Reload the bit timer on acceptance and at every start/data bit boundary
    always_comb begin
        baud_load_c = 1'b0;
        case (state)
            TX_IDLE:           baud_load_c = tx_start;
            TX_START, TX_DATA: baud_load_c = baud_zero;
            default:           baud_load_c = 1'b0;
        endcase
    end

    uart_baud_cnt #(
        .FCLK  (FCLK),
        .FBAUD (FBAUD)
    ) u_baud (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .load   (baud_load_c),
        .zero   (baud_zero),
        .half   (baud_half_unused)
    );

    // Line level is computed one edge ahead so tx always comes straight from a flop
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= UART_STOP_BIT;
            tx_busy <= 1'b0;
            tx_idle <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (tx_start) begin
                        shreg   <= tx_data;
                        bit_cnt <= '0;
                        tx      <= UART_START_BIT;
                        tx_busy <= 1'b1;
                        tx_idle <= 1'b0;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (baud_zero) begin
                        tx    <= shreg[0];
                        state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (baud_zero) begin
                        if (bit_cnt == BCW'(WIDTH - 1)) begin
                            tx    <= UART_STOP_BIT;
                            state <= TX_STOP;
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                TX_STOP: begin
                    if (baud_zero) begin
                        tx      <= UART_STOP_BIT;
                        tx_busy <= 1'b0;
                        tx_idle <= 1'b1;
                        tx_done <= 1'b1;
                        state   <= TX_IDLE;
                    end
                end
                default: begin
                    tx      <= UART_STOP_BIT;
                    tx_busy <= 1'b0;
                    tx_idle <= 1'b1;
                    state   <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected words, a line monitor decodes frames.
module tb_uart_tx;

    localparam int unsigned W  = 8;
    localparam int unsigned B  = 16;
    localparam int unsigned FL = (W + 2) * B;
    localparam int unsigned DB = 50000000 / 115200;

    logic         clk50m;
    logic         rst_n;
    logic [W-1:0] tx_data;
    logic         tx_start;
    logic         tx, tx_busy, tx_idle, tx_done;
    logic [7:0]   d_data;
    logic         d_start;
    logic         d_tx, d_busy, d_idle, d_done;

    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    logic [7:0]   exp_q[$];

    int unsigned  cyc = 0;
    bit           in_frame = 1'b0;
    bit           have_exp = 1'b0;
    logic [7:0]   cur = '0;

    uart_tx #(.WIDTH(W), .FCLK(16), .FBAUD(1)) dut (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .tx_idle  (tx_idle),
        .tx_done  (tx_done)
    );

    uart_tx dut_def (
        .clk50m   (clk50m),
        .rst_n    (rst_n),
        .tx_data  (d_data),
        .tx_start (d_start),
        .tx       (d_tx),
        .tx_busy  (d_busy),
        .tx_idle  (d_idle),
        .tx_done  (d_done)
    );

    initial clk50m = 1'b0;
    always #5 clk50m = ~clk50m;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Frame decoder: a frame is start(0), W data bits LSB first, stop(1), done at FL cycles
    always @(negedge clk50m) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            chk("idle_done", 32'(tx_done), 32'd0);
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                cyc      = 0;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                have_exp = (exp_q.size() != 0);
                if (have_exp) cur = exp_q.pop_front();
            end
        end else begin
            cyc++;
            if (cyc % B == B / 2) begin
                automatic int unsigned k = cyc / B;
                automatic logic want = (k == 0) ? 1'b0 : (k <= W) ? cur[k-1] : 1'b1;
                if (have_exp || k == 0 || k == W + 1)
                    chk($sformatf("bit%0d_of_%02h", k, cur), 32'(tx), 32'(want));
                chk("busy_in_frame", 32'({tx_busy, tx_idle}), 32'b10);
            end
            if (cyc < FL) begin
                chk("early_done", 32'(tx_done), 32'd0);
            end else begin
                chk("frame_end", 32'({tx_done, tx_busy, tx_idle}), 32'b101);
                in_frame = 1'b0;
            end
        end
    end

    // Waits for the line to go idle; scribbles tx_data and optionally pokes tx_start mid-frame
    task automatic wait_idle(input bit noise);
        int unsigned n = 0;
        do begin
            @(negedge clk50m);
            tx_data  = W'($urandom);
            tx_start = noise && in_frame && tx_busy && (cyc + 2 < 9 * B) && ($urandom_range(0, 30) == 0);
            n++;
        end while (!(tx_idle && !in_frame && !tx_start) && n < 4 * FL);
        chk("idle_wait", 32'(n < 4 * FL), 32'd1);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk50m);
        tx_data  = d;
        tx_start = 1'b1;
        exp_q.push_back(d);
        @(negedge clk50m);
        tx_start = 1'b0;
    endtask

    initial begin
        int unsigned n;
        logic [7:0]  v;
        tx_data  = '0;
        tx_start = 1'b0;
        d_data   = '0;
        d_start  = 1'b0;
        rst_n    = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk("reset_vals", 32'({tx, tx_busy, tx_idle, tx_done}), 32'b1010);
        chk("reset_vals_def", 32'({d_tx, d_busy, d_idle, d_done}), 32'b1010);
        repeat (2) @(negedge clk50m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk50m);

        send(8'h55);
        wait_idle(1'b0);
        send(8'h00);
        wait_idle(1'b0);
        send(8'hFF);
        wait_idle(1'b0);

        // start strobe in the middle of DATA must be dropped
        send(8'h81);
        repeat (3 * B + 8) @(negedge clk50m);
        tx_data  = 8'h12;
        tx_start = 1'b1;
        @(negedge clk50m);
        tx_start = 1'b0;
        wait_idle(1'b0);

        // back-to-back: start held in the done cycle stretches stop to B+1
        send(8'hA5);
        n = 0;
        while (tx_done !== 1'b1 && n < 12 * B) begin
            @(negedge clk50m);
            n++;
        end
        chk("b2b_done_seen", 32'(tx_done), 32'd1);
        chk("b2b_line_high", 32'(tx), 32'd1);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        exp_q.push_back(8'h3C);
        @(negedge clk50m);
        tx_start = 1'b0;
        chk("b2b_stop_len", 32'(tx), 32'd0);
        wait_idle(1'b0);

        // start held: each acceptance is FL+1 cycles after the previous one
        @(negedge clk50m);
        v = 8'($urandom);
        tx_data  = v;
        tx_start = 1'b1;
        exp_q.push_back(v);
        for (int f = 0; f < 2; f++) begin
            @(posedge clk50m);
            #1;
            v = 8'($urandom);
            tx_data = v;
            exp_q.push_back(v);
            repeat (FL) @(posedge clk50m);
        end
        @(posedge clk50m);
        #1;
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        wait_idle(1'b0);

        // asynchronous reset during data bit 4
        send(8'h96);
        repeat (4 * B + 8) @(negedge clk50m);
        @(posedge clk50m);
        #1 rst_n = 1'b0;
        #1 chk("abort_reset", 32'({tx, tx_busy, tx_idle, tx_done}), 32'b1010);
        repeat (2) @(negedge clk50m);
        rst_n = 1'b1;
        send(8'hC3);
        wait_idle(1'b0);

        for (int i = 0; i < 30; i++) begin
            wait_idle(1'b1);
            repeat ($urandom_range(0, 4)) @(negedge clk50m);
            send(8'($urandom));
        end
        wait_idle(1'b0);

        // one frame at default parameters (434 cycles per bit)
        v = 8'($urandom);
        @(negedge clk50m);
        d_data  = v;
        d_start = 1'b1;
        @(negedge clk50m);
        d_start = 1'b0;
        d_data  = ~v;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            automatic logic want = (k == 0) ? 1'b0 : (k <= 8) ? v[k-1] : 1'b1;
            while (n < k * DB + DB / 2) begin
                @(negedge clk50m);
                n++;
            end
            chk($sformatf("def_bit%0d", k), 32'({d_tx, d_busy}), 32'({want, 1'b1}));
        end
        while (n < 10 * DB - 1) begin
            @(negedge clk50m);
            n++;
        end
        chk("def_no_early_done", 32'(d_done), 32'd0);
        @(negedge clk50m);
        chk("def_frame_end", 32'({d_done, d_tx, d_idle}), 32'b111);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
